// File: rtl/stack_pkg.sv
// Shared stack/queue definitions: pointer-width helper,
// request decode and top-of-stack source select.
package stack_pkg;

    // Ceiling log2; clog2(17) = 5, clog2(16) = 4, clog2(2) = 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLEAR,
        OP_DROP,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } stack_op_e;

    typedef enum logic [1:0] {
        TOP_HOLD,
        TOP_ZERO,
        TOP_PUSH,
        TOP_MEM
    } top_sel_e;

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Stack pointer control: request priority decode, next
// count, full/empty, sticky errors, write/read addressing.
module stack_ptr_ctrl
    import stack_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int PTR_W       = 5,
    parameter int AW          = 4
) (
    input  logic             clk,
    input  logic             rst_edge,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [PTR_W-1:0] drop_n,
    input  logic             err_clr,
    output logic [PTR_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [AW-1:0]    rd_addr,
    output top_sel_e         top_sel
);

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [PTR_W-1:0] TWO_P   = PTR_W'(2);

    logic [PTR_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [PTR_W:0]   drop_diff;
    logic             new_ovf, new_unf;
    stack_op_e        op;

    assign full  = (count_q == DEPTH_P);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    // Extra MSB acts as the borrow for a drop past the bottom.
    assign drop_diff = {1'b0, count_q} - {1'b0, drop_n};

    // Priority decode: clear > drop > push/pop.
    always_comb begin
        op = OP_NONE;
        if (clear) begin
            op = OP_CLEAR;
        end else if (drop_n != '0) begin
            op = OP_DROP;
        end else if (push && pop) begin
            op = OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    // Next count, write/read addresses and error events.
    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = AW'(count_q);
        rd_addr = '0;
        top_sel = TOP_HOLD;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        unique case (op)
            OP_CLEAR: begin
                count_d = '0;
                top_sel = TOP_ZERO;
            end
            OP_DROP: begin
                if (drop_diff[PTR_W]) begin
                    count_d = '0;
                    top_sel = TOP_ZERO;
                    new_unf = 1'b1;
                end else begin
                    count_d = drop_diff[PTR_W-1:0];
                    rd_addr = AW'(drop_diff[PTR_W-1:0] - ONE_P);
                    top_sel = (drop_diff[PTR_W-1:0] == '0)
                            ? TOP_ZERO : TOP_MEM;
                end
            end
            OP_PUSH: begin
                if (full) begin
                    new_ovf = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + ONE_P;
                    top_sel = TOP_PUSH;
                end
            end
            OP_POP: begin
                if (empty) begin
                    new_unf = 1'b1;
                end else begin
                    count_d = count_q - ONE_P;
                    rd_addr = AW'(count_q - TWO_P);
                    top_sel = (count_q == ONE_P)
                            ? TOP_ZERO : TOP_MEM;
                end
            end
            OP_REPLACE: begin
                wr_en   = 1'b1;
                top_sel = TOP_PUSH;
                if (empty) begin
                    count_d = ONE_P;
                    wr_addr = '0;
                    new_unf = 1'b1;
                end else begin
                    wr_addr = AW'(count_q - ONE_P);
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Sticky flags: a new error beats err_clr in the same cycle.
    always_comb begin
        ovf_d = new_ovf | (ovf_q & ~err_clr);
        unf_d = new_unf | (unf_q & ~err_clr);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or posedge rst_edge) begin
        if (rst_edge) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: rtl/lifo_stack_core.sv
// LIFO stack: register-array storage plus registered
// top-of-stack; pointer logic lives in stack_ptr_ctrl.
module lifo_stack_core
    import stack_pkg::*;
#(
    parameter int  DATA_WIDTH  = 8,
    parameter int  STACK_DEPTH = 16,
    localparam int PTR_W       = clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_edge,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic [PTR_W-1:0]      drop_n,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] top_data,
    output logic [PTR_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf,
    output logic                  unf
);

    localparam int AW = clog2(STACK_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [DATA_WIDTH-1:0] top_data_q, top_data_d;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    top_sel_e              top_sel;

    stack_ptr_ctrl #(
        .STACK_DEPTH (STACK_DEPTH),
        .PTR_W       (PTR_W),
        .AW          (AW)
    ) u_ctrl (
        .clk      (clk),
        .rst_edge (rst_edge),
        .clear    (clear),
        .push     (push),
        .pop      (pop),
        .drop_n   (drop_n),
        .err_clr  (err_clr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .unf      (unf),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .top_sel  (top_sel)
    );

    // Storage array; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= push_data;
        end
    end

    // Next top: read paths never hit the entry written this
    // cycle, since writes always take the push_data path.
    always_comb begin
        top_data_d = top_data_q;
        unique case (top_sel)
            TOP_ZERO: top_data_d = '0;
            TOP_PUSH: top_data_d = push_data;
            TOP_MEM:  top_data_d = mem_q[rd_addr];
            default:  top_data_d = top_data_q;
        endcase
    end

    // Registered top-of-stack.
    always_ff @(posedge clk or posedge rst_edge) begin
        if (rst_edge) begin
            top_data_q <= '0;
        end else begin
            top_data_q <= top_data_d;
        end
    end

    assign top_data = top_data_q;

endmodule

// File: tb/tb_lifo_stack_core.sv
// Bench for lifo_stack_core: directed plan plus random
// traffic against a queue-based stack model.
module tb_lifo_stack_core;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_edge;
    logic             clear;
    logic             push;
    logic [7:0]       push_data;
    logic             pop;
    logic [PTR_W-1:0] drop_n;
    logic             err_clr;
    logic [7:0]       top_data;
    logic [PTR_W-1:0] count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    int total;
    int bad;

    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_unf;

    lifo_stack_core #(
        .DATA_WIDTH  (8),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_edge  (rst_edge),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .drop_n    (drop_n),
        .err_clr   (err_clr),
        .top_data  (top_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Behavioural stack: back of the queue is the top.
    task automatic model_apply(input logic c, input logic ps,
                               input logic pp,
                               input int dn,
                               input logic [7:0] d,
                               input logic ec);
        if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (c) begin
            mq.delete();
        end else if (dn != 0) begin
            if (dn > mq.size()) begin
                mq.delete();
                m_unf = 1'b1;
            end else begin
                repeat (dn) void'(mq.pop_back());
            end
        end else if (ps && pp) begin
            if (mq.size() == 0) begin
                mq.push_back(d);
                m_unf = 1'b1;
            end else begin
                mq[mq.size()-1] = d;
            end
        end else if (ps) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(d);
        end else if (pp) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else void'(mq.pop_back());
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] et;
        et = (mq.size() == 0) ? 8'h00 : mq[mq.size()-1];
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".top"}, 32'(top_data), 32'(et));
        chk({tag, ".full"}, 32'(full),
            32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty),
            32'(mq.size() == 0));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(unf), 32'(m_unf));
    endtask

    task automatic step(input string tag, input logic c,
                        input logic ps, input logic pp,
                        input int dn, input logic [7:0] d,
                        input logic ec);
        clear     = c;
        push      = ps;
        pop       = pp;
        drop_n    = PTR_W'(dn);
        push_data = d;
        err_clr   = ec;
        @(posedge clk);
        #1;
        model_apply(c, ps, pp, dn, d, ec);
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        drop_n  = '0;
        err_clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_edge  = 1'b1;
        clear     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        drop_n    = '0;
        push_data = '0;
        err_clr   = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_edge = 1'b0;

        // Fill 0x01..0x10, then overflow.
        for (int i = 1; i <= DEPTH; i++)
            step("fill", 0, 1, 0, 0, 8'(i), 0);
        chk("fill_full", 32'(full), 32'd1);
        step("push17", 0, 1, 0, 0, 8'hEE, 0);
        chk("push17_top", 32'(top_data), 32'h10);
        chk("push17_ovf", 32'(ovf), 32'd1);

        // Drain, then underflow, then clear the flags.
        for (int i = 0; i < DEPTH; i++)
            step("drain", 0, 0, 1, 0, 8'h00, 0);
        chk("drain_empty", 32'(empty), 32'd1);
        step("pop17", 0, 0, 1, 0, 8'h00, 0);
        chk("pop17_unf", 32'(unf), 32'd1);
        step("errclr", 0, 0, 0, 0, 8'h00, 1);
        chk("errclr_ovf", 32'(ovf), 32'd0);

        // Replace-top.
        step("rp_a1", 0, 1, 0, 0, 8'hA1, 0);
        step("rp_a2", 0, 1, 0, 0, 8'hA2, 0);
        step("rp_55", 0, 1, 1, 0, 8'h55, 0);
        chk("rp_55_top", 32'(top_data), 32'h55);
        step("rp_pop", 0, 0, 1, 0, 8'h00, 0);
        chk("rp_pop_top", 32'(top_data), 32'hA1);
        for (int i = 0; i < DEPTH - 1; i++)
            step("rp_fill", 0, 1, 0, 0, 8'(8'h20 + i), 0);
        step("rp_full77", 0, 1, 1, 0, 8'h77, 0);
        chk("rp_full77_ovf", 32'(ovf), 32'd0);

        // Multi-entry drop.
        step("dr_clr", 1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++)
            step("dr_fill", 0, 1, 0, 0, 8'(i), 0);
        step("drop4", 0, 0, 0, 4, 8'h00, 0);
        chk("drop4_top", 32'(top_data), 32'h05);
        step("drop9", 0, 0, 0, 9, 8'h00, 0);
        chk("drop9_unf", 32'(unf), 32'd1);
        step("dr_p1", 0, 1, 0, 0, 8'h61, 0);
        step("dr_p2", 0, 1, 0, 0, 8'h62, 0);
        step("drop_push", 0, 1, 0, 1, 8'hF0, 0);
        chk("drop_push_top", 32'(top_data), 32'h61);

        // Priority and empty corner.
        step("clr_push", 1, 1, 0, 0, 8'h44, 1);
        chk("clr_push_cnt", 32'(count), 32'd0);
        step("empty_rp", 0, 1, 1, 0, 8'h3C, 0);
        chk("empty_rp_top", 32'(top_data), 32'h3C);

        // Async reset in the middle of a push burst.
        step("ar_clr", 1, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 7; i++)
            step("ar_fill", 0, 1, 0, 0, 8'(8'h70 + i), 0);
        push      = 1'b1;
        push_data = 8'hE7;
        @(negedge clk);
        rst_edge = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        push = 1'b0;
        @(posedge clk);
        #1;
        check_all("async_hold");
        @(negedge clk);
        rst_edge = 1'b0;
        step("ar_push99", 0, 1, 0, 0, 8'h99, 0);
        chk("ar_push99_top", 32'(top_data), 32'h99);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            int   r;
            int   dn;
            logic c, ps, pp, ec;
            r  = int'($urandom_range(0, 99));
            c  = (r < 2);
            dn = (r >= 2 && r < 10)
               ? int'($urandom_range(1, 18)) : 0;
            ps = ($urandom_range(0, 9) < 6);
            pp = ($urandom_range(0, 9) < 4);
            ec = ($urandom_range(0, 19) == 0);
            step("rand", c, ps, pp, dn, 8'($urandom), ec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=done");
        $fatal(1, "timeout");
    end

endmodule
